// File: rtl/md_unit.sv
// Multiply/divide unit: computes mult/multu/div/divu at launch and commits the
// result to HI/LO after a fixed busy latency; also serves mthi/mtlo and mfhi/mflo.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  way,
  input  logic        HIw,
  input  logic        LOw,
  input  logic        mh,
  input  logic        ml,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] WAY_MULT  = 3'b001;
  localparam logic [2:0] WAY_MULTU = 3'b010;
  localparam logic [2:0] WAY_DIV   = 3'b011;
  localparam logic [2:0] WAY_DIVU  = 3'b100;

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip_q, skip_d;

  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, divisor_u, divisor_m;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;

  // Datapath: signed division is done on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 without a special case.
  always_comb begin
    a_neg     = rs_data[31];
    b_neg     = rt_data[31];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
    prod_s    = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u    = {32'd0, rs_data} * {32'd0, rt_data};
    div_zero  = (rt_data == 32'd0);
    divisor_u = div_zero ? 32'd1 : rt_data;
    divisor_m = div_zero ? 32'd1 : b_mag;
    q_u       = rs_data / divisor_u;
    r_u       = rs_data % divisor_u;
    q_m       = a_mag / divisor_m;
    r_m       = a_mag % divisor_m;
    q_s       = (a_neg ^ b_neg) ? -q_m : q_m;
    r_s       = a_neg ? -r_m : r_m;
  end

  // Next state: busy countdown/commit has priority, then flush, start, mthi/mtlo.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !skip_q) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end else if (!req) begin
      if (start) begin
        case (way)
          WAY_MULT: begin
            hi_tmp_d = prod_s[63:32];
            lo_tmp_d = prod_s[31:0];
            skip_d   = 1'b0;
            cnt_d    = CNT_W'(MULT_CYCLES);
          end
          WAY_MULTU: begin
            hi_tmp_d = prod_u[63:32];
            lo_tmp_d = prod_u[31:0];
            skip_d   = 1'b0;
            cnt_d    = CNT_W'(MULT_CYCLES);
          end
          WAY_DIV: begin
            hi_tmp_d = r_s;
            lo_tmp_d = q_s;
            skip_d   = div_zero;
            cnt_d    = CNT_W'(DIV_CYCLES);
          end
          WAY_DIVU: begin
            hi_tmp_d = r_u;
            lo_tmp_d = q_u;
            skip_d   = div_zero;
            cnt_d    = CNT_W'(DIV_CYCLES);
          end
          default: ;
        endcase
      end else begin
        if (HIw) hi_d = rs_data;
        if (LOw) lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
    end
  end

  assign busy   = (cnt_q != '0);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = mh ? hi_q : (ml ? lo_q : 32'd0);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed and random operations checked by a scoreboard
// whose expectations come from a longint arithmetic model.
module tb_md_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, req, start, HIw, LOw, mh, ml;
  logic [2:0]  way;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .way(way),
    .HIw(HIw), .LOw(LOw), .mh(mh), .ml(ml),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  exp_t        scb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_hi    = 32'd0;
  logic [31:0] model_lo    = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: updates model HI/LO, returns 0 for ignored way codes.
  function automatic bit model_op(input logic [2:0] w, input logic [31:0] a, input logic [31:0] b,
                                  output int unsigned lat);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     v;
    model_op = 1'b1;
    lat      = 0;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (w)
      3'd1: begin v = sa * sbv; model_hi = v[63:32]; model_lo = v[31:0]; lat = MULT_N; end
      3'd2: begin v = ua * ub;  model_hi = v[63:32]; model_lo = v[31:0]; lat = MULT_N; end
      3'd3: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          q = sa / sbv;
          r = sa % sbv;
          v = q; model_lo = v[31:0];
          v = r; model_hi = v[31:0];
        end
      end
      3'd4: begin
        lat = DIV_N;
        if (b != 32'd0) begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
      default: model_op = 1'b0;
    endcase
  endfunction

  // Monitor: on each busy fall, compare HI/LO and busy length with the oldest expectation.
  initial begin : monitor
    bit   prev_busy;
    int   run;
    exp_t e;
    prev_busy = 1'b0;
    run       = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        run       = 0;
      end else if (busy) begin
        prev_busy = 1'b1;
        run++;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        if (scb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scb_underflow: busy fell with no expected result at %0t", $time);
        end else begin
          e = scb.pop_front();
          chk("op_hi", hi, e.hi);
          chk("op_lo", lo, e.lo);
          chk("op_latency", 32'(run), 32'(e.lat));
        end
        run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  // Issue one op (called just after a negedge); operands are scrambled after launch.
  task automatic run_op(input logic [2:0] w, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int unsigned lat;
    start   = 1'b1;
    way     = w;
    rs_data = a;
    rt_data = b;
    if (model_op(w, a, b, lat)) begin
      e.hi = model_hi; e.lo = model_lo; e.lat = lat;
      scb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    wait_idle();
  endtask

  task automatic check_mdout();
    mh = 1'b1; ml = 1'b0; #1 chk("md_out_hi", md_out, model_hi);
    mh = 1'b0; ml = 1'b1; #1 chk("md_out_lo", md_out, model_lo);
    mh = 1'b1; ml = 1'b1; #1 chk("md_out_pri", md_out, model_hi);
    mh = 1'b0; ml = 1'b0; #1 chk("md_out_none", md_out, 32'd0);
  endtask

  initial begin : stim
    exp_t        e;
    int unsigned lat;
    logic [31:0] a, b;
    logic [2:0]  w;
    reset = 1'b0; req = 1'b0; start = 1'b0; way = 3'd0; HIw = 1'b0; LOw = 1'b0;
    mh = 1'b1; ml = 1'b0; rs_data = 32'd0; rt_data = 32'd0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_md_out", md_out, 32'd0);
    mh = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    run_op(3'd2, 32'hFFFFFFFF, 32'd2);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    mh = 1'b1; #1 chk("mfhi", md_out, 32'h00000001);
    mh = 1'b0; ml = 1'b1; #1 chk("mflo", md_out, 32'hFFFFFFFE);
    ml = 1'b0;

    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd4, 32'h12345678, 32'd0);
    chk("divu0_hi", hi, 32'hFFFFFFFF);
    chk("divu0_lo", lo, 32'hFFFFFFFD);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    // Flushed start and flushed mthi, then an invalid way code.
    @(negedge clk);
    req = 1'b1; start = 1'b1; way = 3'd1; rs_data = 32'd7; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0; HIw = 1'b1; rs_data = 32'hCAFEF00D;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, model_hi);
    chk("flush_lo", lo, model_lo);
    @(negedge clk);
    req = 1'b0; HIw = 1'b0;
    chk("flush_mthi", hi, model_hi);
    start = 1'b1; way = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("bad_way_busy", {31'd0, busy}, 32'd0);

    // mthi while busy must be dropped.
    start = 1'b1; way = 3'd1; rs_data = 32'd1000; rt_data = 32'hFFFFFFFF;
    void'(model_op(3'd1, 32'd1000, 32'hFFFFFFFF, lat));
    e.hi = model_hi; e.lo = model_lo; e.lat = lat;
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0; HIw = 1'b1; rs_data = 32'h12345678;
    @(negedge clk);
    HIw = 1'b0;
    wait_idle();
    chk("busy_mthi_hi", hi, 32'hFFFFFFFF);

    // Back-to-back mthi / mtlo.
    @(negedge clk);
    HIw = 1'b1; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    HIw = 1'b0; LOw = 1'b1; rs_data = 32'h0BADF00D;
    @(negedge clk);
    LOw = 1'b0;
    chk("mtlo_lo", lo, 32'h0BADF00D);
    chk("mtlo_hi_kept", hi, 32'hDEADBEEF);
    model_hi = 32'hDEADBEEF; model_lo = 32'h0BADF00D;

    // Random mix of operations and moves.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 7));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        HIw = $urandom_range(0, 1) == 1;
        LOw = !HIw || ($urandom_range(0, 1) == 1);
        rs_data = a;
        @(negedge clk);
        if (HIw) model_hi = a;
        if (LOw) model_lo = a;
        HIw = 1'b0; LOw = 1'b0;
        chk("rnd_mv_hi", hi, model_hi);
        chk("rnd_mv_lo", lo, model_lo);
      end else begin
        w = 3'($urandom_range(1, 4));
        run_op(w, a, b);
        check_mdout();
      end
    end

    // Asynchronous reset in the middle of a divide.
    run_op(3'd2, 32'd77, 32'd3);
    start = 1'b1; way = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    void'(model_op(3'd3, 32'd100, 32'd7, lat));
    e.hi = model_hi; e.lo = model_lo; e.lat = lat;
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    scb.delete();
    model_hi = 32'd0; model_lo = 32'd0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    mh = 1'b1; #1 chk("rst_mid_md_out", md_out, 32'd0);
    mh = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'd2, 32'd3);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    repeat (2) @(negedge clk);
    chk("scb_empty", 32'(scb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the P7 pipeline, driven by the instruction decoder's `start`, `way`, `HIw`, `LOw`, `mh` and `ml` controls. It accepts one mult/multu/div/divu operation at a time and holds the result in the HI/LO registers. It asserts `busy` for a fixed multi-cycle latency; the hazard unit uses `busy` to stall md-class instructions. The unit also serves mthi/mtlo writes and mfhi/mflo reads.

## Interface
- MULT_CYCLES, 5, busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, busy duration for div/divu (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req  in  1  exception/interrupt flush of the E-stage instruction; when 1, `start`/`HIw`/`LOw` in that cycle are ignored
- start  in  1  launch operation selected by `way`
- way  in  3  001 mult, 010 multu, 011 div, 100 divu; any other code with `start` is ignored
- HIw  in  1  mthi: write `rs_data` to HI
- LOw  in  1  mtlo: write `rs_data` to LO
- mh  in  1  select HI on `md_out`
- ml  in  1  select LO on `md_out`
- rs_data  in  32  operand A / dividend / mthi-mtlo data
- rt_data  in  32  operand B / divisor
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  mh ? hi : ml ? lo : 0 (combinational)

## Operation
- State: `hi`, `lo`, `hi_tmp`, `lo_tmp`, a down-counter `cnt`, and a flag `skip`.
- Idle is `cnt == 0`. `busy = (cnt != 0)`, registered-equivalent.
- Accepted `start` (req=0, busy=0, valid `way`):
  - Compute the result combinationally from the current `rs_data`/`rt_data` into `hi_tmp`/`lo_tmp`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- mult: signed 64-bit product; hi = [63:32], lo = [31:0].
- multu: unsigned 64-bit product.
- div:
  - Signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- divu: unsigned quotient to lo, remainder to hi.
- Divisor 0 (div/divu): operation still occupies DIV_CYCLES; `skip` = 1 and HI/LO keep their old values.
- Completion (cnt == 1 at a rising edge): `cnt` goes to 0; if !skip, hi <= hi_tmp and lo <= lo_tmp.
- HIw/LOw (req=0, busy=0, start=0): at the edge, hi <= rs_data (HIw) or lo <= rs_data (LOw).
- Ignored while busy: `start`, `HIw` and `LOw` (the hazard unit guarantees none arrive). They cause no state change.
- Priority within one cycle: req > start > HIw/LOw.
- `req` does not abort an operation already in flight; it completes and commits normally.
- Reset (asynchronous, any time, including mid-operation):
  - hi, lo, hi_tmp, lo_tmp = 0; cnt = 0; skip = 0.
  - Outputs: busy = 0, hi = 0, lo = 0, md_out = 0.

## Timing
- `start` sampled at edge E0. `busy` = 1 from after E0 through after E(N−1), where N is the latency; `busy` = 0 after EN.
- `hi`/`lo` carry the new result after EN. This is the same edge at which `busy` falls, so a stalled mfhi/mflo released that cycle reads the new value.
- A new `start` is accepted in the cycle after `busy` falls, i.e. sampled at EN+1 at the earliest.
- mthi/mtlo: `hi`/`lo` update at the sampling edge, giving 1-cycle write latency.
- `md_out` has no latency relative to `hi`/`lo`/`mh`/`ml`.
- Operands are sampled only at the start edge; later changes to `rs_data`/`rt_data` have no effect on the result.

## Test plan
- mult, rs=0xFFFFFFFE, rt=3, start for 1 cycle:
  - busy is high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, rs=0xFFFFFFFF, rt=2: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Then mh=1 → md_out=0x00000001; ml=1 → md_out=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (−7), rt=2:
  - busy is high 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then divu with rt=0: busy is high 10 cycles and hi/lo are unchanged.
- Flush and busy suppression:
  - start=1, way=001 with req=1: busy stays 0 and hi/lo are unchanged.
  - HIw=1 with req=1: hi is unchanged.
  - HIw with rs=0x12345678 while busy: ignored.
- mthi rs=0xDEADBEEF, then mtlo rs=0x0BADF00D on consecutive cycles: hi=0xDEADBEEF one cycle after the first, lo=0x0BADF00D one cycle after the second.
- Reset mid-operation:
  - Start div; reset=0 at cycle 4 (asynchronous, between edges): busy, hi, lo are 0 immediately.
  - After release, a new mult 2*3 completes 5 cycles later with lo=6, hi=0.
